// File: rtl/ahb_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slave_regs
// Description : AHB-Lite responder with a bank of NUM_REGS read/write word
//               registers plus one read-only SUM word (reg[0] + reg[1]).
//               Every OKAY data phase carries WAIT_STATES wait cycles.
//               Build option AHB_SLAVE_ERR_EN: when defined, illegal accesses
//               get the two-cycle ERROR response; when undefined they finish
//               as OKAY transfers, writes are dropped and reads return 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_slave_regs #(
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  // Counter load value and word index of the read-only SUM location
  localparam logic [2:0] c_wait_load = 3'(WAIT_STATES);
  localparam logic [4:0] c_sum_idx   = 5'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  // Transfer sequencing state
  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        hreadyout_q;
`ifdef AHB_SLAVE_ERR_EN
  logic        hresp_q;
`endif

  // Attributes of the transfer currently in its data phase
  logic        dphase_q;
  logic        dphase_d;
  logic        write_q;
  logic        legal_q;
  logic [3:0]  widx_q;

  // Operand register bank
  logic [31:0] regs_q [NUM_REGS];

  logic [4:0]  w_widx;
  logic        w_accept;
  logic        w_legal;
  logic        w_commit;
  logic [31:0] w_sum;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // Only haddr[5:0] is decoded and htrans[0] does not distinguish NONSEQ/SEQ
  assign w_unused = ^{haddr[31:6], htrans[0]};

  // Zero-extended word index so the SUM comparison also works for NUM_REGS=16
  assign w_widx = {1'b0, haddr[5:2]};

  // A new address phase is taken only while this slave is itself ready, so a
  // stalled data phase can never be overwritten by a second acceptance.
  assign w_accept = hsel & hready & htrans[1] & hreadyout_q;

  // Aligned word access to a R/W register, or a read of SUM
  assign w_legal = (haddr[1:0] == 2'b00) &&
                   (hsize == 3'b010) &&
                   ((w_widx < c_sum_idx) || ((w_widx == c_sum_idx) && !hwrite));

  // A write lands only in the completing cycle of a legal write data phase;
  // error phases carry legal_q=0 so they can never reach the bank.
  assign w_commit = dphase_q & hreadyout_q & write_q & legal_q;

  // Carry out of bit 31 is intentionally discarded
  assign w_sum = regs_q[0] + regs_q[1];

  // Transfer sequencing: state, wait counter and registered handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      hreadyout_q <= 1'b1;
`ifdef AHB_SLAVE_ERR_EN
      hresp_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q <= 3'd1) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
`ifdef AHB_SLAVE_ERR_EN
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
`endif
        // IDLE and ERR2 both complete a phase and may accept the next one
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= 3'd0;
          hreadyout_q <= 1'b1;
`ifdef AHB_SLAVE_ERR_EN
          hresp_q     <= 1'b0;
`endif
          if (w_accept) begin
`ifdef AHB_SLAVE_ERR_EN
            if (!w_legal) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (c_wait_load != 3'd0) begin
              state_q     <= S_WAIT;
              cnt_q       <= c_wait_load;
              hreadyout_q <= 1'b0;
            end
`else
            if (c_wait_load != 3'd0) begin
              state_q     <= S_WAIT;
              cnt_q       <= c_wait_load;
              hreadyout_q <= 1'b0;
            end
`endif
          end
        end
      endcase
    end
  end

  // Data phase ends in any cycle where this slave is ready, unless a new
  // address phase is accepted on that same edge
  always_comb begin
    dphase_d = dphase_q;
    if (w_accept) begin
      dphase_d = 1'b1;
    end else if (hreadyout_q) begin
      dphase_d = 1'b0;
    end
  end

  // Capture address-phase attributes for use during the data phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      legal_q  <= 1'b0;
      widx_q   <= 4'd0;
    end else begin
      dphase_q <= dphase_d;
      if (w_accept) begin
        widx_q  <= haddr[5:2];
        write_q <= hwrite;
        legal_q <= w_legal;
      end
    end
  end

  // Register bank update on the edge that completes a legal write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (widx_q == 4'(i)) begin
          regs_q[i] <= hwdata;
        end
      end
    end
  end

  // Read value selection from the bank or the SUM word
  always_comb begin
    w_rd_val = 32'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (widx_q == 4'(i)) begin
        w_rd_val = regs_q[i];
      end
    end
    if ({1'b0, widx_q} == c_sum_idx) begin
      w_rd_val = w_sum;
    end
  end

  assign hrdata    = (dphase_q && !write_q && legal_q) ? w_rd_val : 32'd0;
  assign hreadyout = hreadyout_q;
`ifdef AHB_SLAVE_ERR_EN
  assign hresp     = hresp_q;
`else
  assign hresp     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_slave_regs
// Description : Bench for ahb_lite_slave_regs. Two instances are driven:
//               index 0 with WAIT_STATES=0, index 1 with WAIT_STATES=1.
//               Expected values come from a word-array model of the register
//               map. Honours AHB_SLAVE_ERR_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_slave_regs;

  localparam int NREGS = 4;
`ifdef AHB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        hsel_s      [2];
  logic [31:0] haddr_s     [2];
  logic [1:0]  htrans_s    [2];
  logic        hwrite_s    [2];
  logic [2:0]  hsize_s     [2];
  logic [31:0] hwdata_s    [2];
  logic        gate_s      [2];
  logic        hready_s    [2];
  logic        hreadyout_s [2];
  logic        hresp_s     [2];
  logic [31:0] hrdata_s    [2];

  int          vecs;
  int          errs;
  bit   [31:0] model [2][16];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    // Single-slave bus: bus ready follows this slave, optionally held low
    assign hready_s[k] = hreadyout_s[k] & gate_s[k];

    ahb_lite_slave_regs #(
      .NUM_REGS    (NREGS),
      .WAIT_STATES ((k == 0) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .hsel      (hsel_s[k]),
      .haddr     (haddr_s[k]),
      .htrans    (htrans_s[k]),
      .hwrite    (hwrite_s[k]),
      .hsize     (hsize_s[k]),
      .hwdata    (hwdata_s[k]),
      .hready    (hready_s[k]),
      .hreadyout (hreadyout_s[k]),
      .hresp     (hresp_s[k]),
      .hrdata    (hrdata_s[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle(input int k);
    hsel_s[k]   = 1'b0;
    haddr_s[k]  = 32'd0;
    htrans_s[k] = 2'b00;
    hwrite_s[k] = 1'b0;
    hsize_s[k]  = 3'b010;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        model[k][i] = 32'd0;
  endtask

  // One non-pipelined transfer; timing, response and data checked against
  // the register map rules. Called and returns at posedge+1.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    int          w;
    bit          legal;
    logic [31:0] exp_rd;
    int          lows;
    w      = int'(addr[5:2]);
    legal  = (addr[1:0] == 2'b00) && (size == 3'b010) &&
             ((w < NREGS) || ((w == NREGS) && !wr));
    exp_rd = 32'd0;
    if (!wr && legal)
      exp_rd = (w < NREGS) ? model[k][w] : (model[k][0] + model[k][1]);
    hsel_s[k]   = 1'b1;
    haddr_s[k]  = addr;
    htrans_s[k] = 2'b10;
    hwrite_s[k] = wr;
    hsize_s[k]  = size;
    @(posedge clk); #1;
    bus_idle(k);
    hwdata_s[k] = wdata;
    if (ERR_EN && !legal) begin
      check("err1_hreadyout", hreadyout_s[k], 1'b0);
      check("err1_hresp", hresp_s[k], 1'b1);
      check("err1_hrdata", hrdata_s[k], 32'd0);
      @(posedge clk); #1;
      check("err2_hreadyout", hreadyout_s[k], 1'b1);
      check("err2_hresp", hresp_s[k], 1'b1);
      check("err2_hrdata", hrdata_s[k], 32'd0);
    end else begin
      lows = 0;
      while (hreadyout_s[k] !== 1'b1 && lows < 16) begin
        check("wait_hresp", hresp_s[k], 1'b0);
        lows++;
        @(posedge clk); #1;
      end
      check("wait_count", 32'(lows), 32'(ws_of(k)));
      check("done_hresp", hresp_s[k], 1'b0);
      check("done_hrdata", hrdata_s[k], exp_rd);
    end
    if (wr && legal) model[k][w] = wdata;
    @(posedge clk); #1;
    hwdata_s[k] = 32'd0;
    check("after_hreadyout", hreadyout_s[k], 1'b1);
    check("after_hresp", hresp_s[k], 1'b0);
  endtask

  initial begin
    int          k;
    bit          wr;
    int          w;
    logic [31:0] a;
    logic [2:0]  sz;

    vecs = 0;
    errs = 0;
    clear_model();
    for (int i = 0; i < 2; i++) begin
      bus_idle(i);
      hwdata_s[i] = 32'd0;
      gate_s[i]   = 1'b1;
    end
    resetn = 1'b0;

    // Reset state on both instances
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_hreadyout", hreadyout_s[i], 1'b1);
      check("rst_hresp", hresp_s[i], 1'b0);
      check("rst_hrdata", hrdata_s[i], 32'd0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;

    // Registers read back zero after reset
    for (int i = 0; i < 4; i++) xfer(1, 1'b0, 32'(i * 4), 3'b010, 32'd0);

    // Basic writes and SUM
    xfer(1, 1'b1, 32'h00, 3'b010, 32'd1);
    xfer(1, 1'b1, 32'h04, 3'b010, 32'd2);
    xfer(1, 1'b0, 32'h10, 3'b010, 32'd0);
    check("sum_1_plus_2", model[1][0] + model[1][1], 32'd3);

    // SUM wraps with carry dropped
    xfer(1, 1'b1, 32'h00, 3'b010, 32'hFFFF_FFFF);
    xfer(1, 1'b1, 32'h04, 3'b010, 32'd2);
    xfer(1, 1'b0, 32'h10, 3'b010, 32'd0);

    // Back-to-back write then read on the zero-wait instance
    hsel_s[0]   = 1'b1;
    haddr_s[0]  = 32'h08;
    htrans_s[0] = 2'b10;
    hwrite_s[0] = 1'b1;
    hsize_s[0]  = 3'b010;
    @(posedge clk); #1;
    check("b2b_wr_hreadyout", hreadyout_s[0], 1'b1);
    check("b2b_wr_hrdata", hrdata_s[0], 32'd0);
    hwdata_s[0] = 32'hA5A5_A5A5;
    hwrite_s[0] = 1'b0;
    @(posedge clk); #1;
    model[0][2] = 32'hA5A5_A5A5;
    check("b2b_rd_hreadyout", hreadyout_s[0], 1'b1);
    check("b2b_rd_hrdata", hrdata_s[0], 32'hA5A5_A5A5);
    bus_idle(0);
    hwdata_s[0] = 32'd0;
    @(posedge clk); #1;

    // Illegal accesses: unaligned, write to SUM, halfword, beyond SUM
    xfer(1, 1'b0, 32'h09, 3'b010, 32'd0);
    xfer(1, 1'b1, 32'h10, 3'b010, 32'h1234_5678);
    xfer(1, 1'b1, 32'h00, 3'b001, 32'h0000_0077);
    xfer(1, 1'b0, 32'h14, 3'b010, 32'd0);
    xfer(0, 1'b1, 32'h0A, 3'b010, 32'hDEAD_BEEF);
    xfer(1, 1'b0, 32'h00, 3'b010, 32'd0);
    xfer(1, 1'b0, 32'h10, 3'b010, 32'd0);
    xfer(0, 1'b0, 32'h08, 3'b010, 32'd0);

    // BUSY and deselected NONSEQ start nothing
    hsel_s[1]   = 1'b1;
    haddr_s[1]  = 32'h00;
    htrans_s[1] = 2'b01;
    hwrite_s[1] = 1'b1;
    @(posedge clk); #1;
    hwdata_s[1] = 32'h1111_2222;
    check("busy_hreadyout", hreadyout_s[1], 1'b1);
    check("busy_hresp", hresp_s[1], 1'b0);
    hsel_s[1]   = 1'b0;
    htrans_s[1] = 2'b10;
    @(posedge clk); #1;
    check("nosel_hreadyout", hreadyout_s[1], 1'b1);
    check("nosel_hrdata", hrdata_s[1], 32'd0);
    bus_idle(1);
    @(posedge clk); #1;
    hwdata_s[1] = 32'd0;
    xfer(1, 1'b0, 32'h00, 3'b010, 32'd0);

    // Address phase with bus ready low is ignored
    gate_s[1]   = 1'b0;
    hsel_s[1]   = 1'b1;
    haddr_s[1]  = 32'h0C;
    htrans_s[1] = 2'b10;
    hwrite_s[1] = 1'b1;
    @(posedge clk); #1;
    check("nordy_hreadyout", hreadyout_s[1], 1'b1);
    bus_idle(1);
    gate_s[1]   = 1'b1;
    hwdata_s[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hwdata_s[1] = 32'd0;
    xfer(1, 1'b0, 32'h0C, 3'b010, 32'd0);

    // Randomized transfers against the model
    for (int n = 0; n < 160; n++) begin
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_FFC0) | (32'(w) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      xfer(k, wr, a, sz, $urandom);
    end
    for (int i = 0; i <= NREGS; i++) xfer(1, 1'b0, 32'(i * 4), 3'b010, 32'd0);

    // Reset asserted in the wait cycle of a write aborts it
    hsel_s[1]   = 1'b1;
    haddr_s[1]  = 32'h0C;
    htrans_s[1] = 2'b10;
    hwrite_s[1] = 1'b1;
    @(posedge clk); #1;
    bus_idle(1);
    hwdata_s[1] = 32'h55;
    check("abort_in_wait", hreadyout_s[1], 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_hreadyout", hreadyout_s[1], 1'b1);
    check("abort_hresp", hresp_s[1], 1'b0);
    check("abort_hrdata", hrdata_s[1], 32'd0);
    @(posedge clk); #1;
    hwdata_s[1] = 32'd0;
    clear_model();
    resetn = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h0C, 3'b010, 32'd0);
    xfer(1, 1'b0, 32'h00, 3'b010, 32'd0);
    xfer(0, 1'b0, 32'h08, 3'b010, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_lite_slave_regs.md
# ahb_lite_slave_regs

AHB-Lite responder that terminates the transfers issued by the team's AHB master wrapper. It holds a small bank of 32-bit word registers for operands. It also exposes one read-only word that returns the sum of operand registers 0 and 1. It inserts a configurable number of wait states per transfer and signals illegal accesses with the two-cycle AHB ERROR response. It sits on the slave side of the interconnect and is selected by the decoder through `hsel`.

## Interface
Parameters:
- `NUM_REGS`, default 4: number of read/write word registers at word offsets 0..NUM_REGS-1. Must be 2 to 16.
- `WAIT_STATES`, default 1: number of `hreadyout`-low cycles in every OKAY data phase. Range 0 to 7.

Ports:
- `clk` input 1: the block's single clock; all state changes on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `hsel` input 1: slave select from the decoder.
- `haddr` input 32: byte address. Only bits [5:0] are decoded.
- `htrans` input 2: transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `hwrite` input 1: 1 = write, 0 = read.
- `hsize` input 3: transfer size. Only 3'b010 (word) is legal.
- `hwdata` input 32: write data, valid in the data phase.
- `hready` input 1: bus-level ready; an address phase is accepted only when it is high.
- `hreadyout` output 1: this slave's ready.
- `hresp` output 1: 0 = OKAY, 1 = ERROR.
- `hrdata` output 32: read data.

## Operation
- **Address phase acceptance:**
  - Accepted on a rising edge with `hsel`=1, `hready`=1 and `htrans[1]`=1.
  - On acceptance, latch `haddr[5:2]`, `hwrite`, and a legal flag.
  - IDLE/BUSY transfers, or `hsel`=0, start nothing and get a zero-wait OKAY.
- **Register map (word index w = `haddr[5:2]`):**
  - w < NUM_REGS: read/write register.
  - w = NUM_REGS: SUM, read-only, reg[0]+reg[1] modulo 2^32 with carry discarded.
  - Any other w is illegal.
- **Illegal access:** any of the following.
  - `haddr[1:0]` ≠ 0.
  - `hsize` ≠ 3'b010.
  - w > NUM_REGS.
  - A write to SUM.
- **State machine:** states IDLE, WAIT, ERR1, ERR2.
  - IDLE: `hreadyout`=1, `hresp`=0.
    - Legal accept with WAIT_STATES=0: remain in IDLE; the next cycle is the completing data phase.
    - Legal accept with WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES.
    - Illegal accept: go to ERR1.
  - WAIT: `hreadyout`=0.
    - The counter decrements each cycle.
    - When the counter reaches 1, go to IDLE; that next cycle is the completing cycle with `hreadyout`=1.
  - ERR1: `hreadyout`=0, `hresp`=1. Always go to ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1. Go to IDLE, or accept a new address phase exactly as IDLE does.
- **Write commit:**
  - `hwdata` is written into reg[w] on the rising edge that ends the completing OKAY data phase (`hreadyout`=1).
  - Erroring transfers never modify registers.
- **Read data:**
  - During a read data phase, `hrdata` is driven combinationally from the current register contents or SUM.
  - It is 0 at all other times, including error phases.
- **Pipelining:**
  - A new address phase is accepted on the same edge that completes the previous data phase.
  - A read issued immediately after a write to the same register returns the newly written value.
- **Reset:**
  - Asserting `resetn` mid-transfer aborts it immediately: state IDLE, counter 0, all registers 0.
  - No partial write is committed.

## Timing
- Reset values: `hreadyout`=1, `hresp`=0, `hrdata`=0.
- OKAY transfer: address phase at edge N; data phase spans cycles N+1 .. N+1+WAIT_STATES, with `hreadyout` high only in the last of these cycles.
- ERROR transfer: `hresp`=1 for exactly two cycles (N+1 with `hreadyout`=0, N+2 with `hreadyout`=1), independent of WAIT_STATES.
- Peak throughput is one transfer per WAIT_STATES+1 cycles.
- An address phase presented while `hready`=0 is ignored; the master must hold it.

## Configuration
- `AHB_SLAVE_ERR_EN`
  - Defined: illegal accesses receive the two-cycle ERROR response described above.
  - Undefined: illegal accesses complete as normal OKAY transfers with WAIT_STATES timing; writes are discarded and reads return 0. ERR1/ERR2 are not built and `hresp` is tied to 0.

## Test plan
- Reset then idle bus → `hreadyout`=1, `hresp`=0, `hrdata`=0; reading words 0..3 returns 0.
- WAIT_STATES=1: write 1 to 0x00 and 2 to 0x04 → each data phase has one `hreadyout`-low cycle; then a read of 0x10 returns 3.
- Write 0xFFFFFFFF to 0x00 and 2 to 0x04, then read 0x10 → 0x00000001 (carry dropped).
- WAIT_STATES=0, back-to-back write 0xA5A5A5A5 to 0x08 followed by a read of 0x08 → read data 0xA5A5A5A5 in the cycle after the write completes, with no stall.
- With `AHB_SLAVE_ERR_EN` defined, an access to address 9 (unaligned), a write to 0x10, or a halfword `hsize` → two-cycle ERROR (0/1 then 1/1 on `hreadyout`/`hresp`) and no register change. Without the macro, the same stimulus gives OKAY and reads return 0.
- Deassert `resetn` during a WAIT cycle of a write of 0x55 to 0x0C → outputs return to reset values immediately and a later read of 0x0C returns 0.
